// File: rtl/fpmroc_tdc_pkg.sv
// Shared constants and types for the FPMROC TDC fine-time path.
// The 55-stage ring snapshot is encoded as 11 groups of 5 stages.
package fpmroc_tdc_pkg;

  localparam int FINE_W     = 55;
  localparam int FINE_GRP   = 11;
  localparam int GRP_W      = 5;
  localparam int FINE_BIN_W = 7;
  localparam int FINE_MAX   = 109;
  localparam int GRP_OFF_W  = 3;

  typedef struct packed {
    logic [FINE_BIN_W-1:0] code;
    logic                  err;
  } fine_result_t;

endpackage

// File: rtl/fine_group_enc.sv
// Transition detector for one 5-stage group of the ring snapshot.
// Bit 0 of the group is compared against the MSB of the group below it.
module fine_group_enc
  import fpmroc_tdc_pkg::*;
(
  input  logic [GRP_W-1:0]     grp,
  input  logic                 prev_msb,
  output logic                 trans,
  output logic                 multi,
  output logic [GRP_OFF_W-1:0] offset
);

  logic [GRP_W-1:0] diff;

  // diff[i] set means stage i differs from the stage just below it.
  assign diff  = grp ^ {grp[GRP_W-2:0], prev_msb};
  assign trans = |diff;
  assign multi = |(diff & (diff - GRP_W'(1)));

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise synthesis infers a latch for the unassigned paths.
  always_comb begin
    offset = '0;
    for (int i = GRP_W - 1; i >= 0; i--) begin
      if (diff[i]) offset = GRP_OFF_W'(i);
    end
  end

endmodule

// File: rtl/fine_data_encoder.sv
// Fine-time encoder: 55-bit ring snapshot -> registered 7-bit code 0..109
// plus a bubble/invalid flag. One cycle latency, one code per cycle.
module fine_data_encoder
  import fpmroc_tdc_pkg::*;
(
  input  logic                  clk40M,
  input  logic                  rst_n,
  input  logic [FINE_W-1:0]     fine_raw_code,
  output logic [FINE_BIN_W-1:0] fine_bin_code,
  output logic                  fine_code_err
);

  logic [FINE_GRP-1:0]  prev_msb;
  logic [FINE_GRP-1:0]  xor_res1;
  logic [FINE_GRP-1:0]  and_res1;
  logic [FINE_GRP-1:0]  xor_res2;
  logic [FINE_GRP-1:0]  grp_multi;
  logic [GRP_OFF_W-1:0] grp_off [FINE_GRP];

  logic                  v;
  logic [FINE_BIN_W-1:0] run_len;
  logic [FINE_BIN_W-1:0] pos;
  fine_result_t          res_d;
  fine_result_t          res_q;

  assign v = fine_raw_code[0];

  // Group 0 compares stage 0 with itself, so it never flags at bit 0.
  always_comb begin
    prev_msb    = '0;
    prev_msb[0] = fine_raw_code[0];
    for (int g = 1; g < FINE_GRP; g++) begin
      prev_msb[g] = fine_raw_code[g*GRP_W-1];
    end
  end

  for (genvar g = 0; g < FINE_GRP; g++) begin : g_grp
    fine_group_enc u_enc (
      .grp      (fine_raw_code[g*GRP_W +: GRP_W]),
      .prev_msb (prev_msb[g]),
      .trans    (xor_res1[g]),
      .multi    (grp_multi[g]),
      .offset   (grp_off[g])
    );
  end

  // Lowest flagged group wins; any other flagged group is a bubble.
  assign and_res1 = xor_res1 & (~xor_res1 + FINE_GRP'(1));
  assign xor_res2 = xor_res1 & ~and_res1;

  // pos is the index of the first stage that differs from stage 0, which
  // equals the run length p; with no transition the whole ring is one run.
  always_comb begin
    pos = '0;
    for (int g = 0; g < FINE_GRP; g++) begin
      if (and_res1[g]) begin
        pos = pos | (FINE_BIN_W'(g*GRP_W) + {{(FINE_BIN_W-GRP_OFF_W){1'b0}}, grp_off[g]});
      end
    end
    run_len    = (|xor_res1) ? pos : FINE_BIN_W'(FINE_W);
    res_d.code = v ? (run_len - FINE_BIN_W'(1)) : (run_len + FINE_BIN_W'(FINE_W - 1));
    res_d.err  = (|xor_res2) | (|grp_multi);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign fine_bin_code = res_q.code;
  assign fine_code_err = res_q.err;

endmodule

// File: tb/tb_fine_data_encoder.sv
// Self-checking bench for fine_data_encoder: directed table, reset and
// multi-cycle sequences, and a random stream against a run-length model.
module tb_fine_data_encoder;

  logic        clk40M;
  logic        rst_n;
  logic [54:0] fine_raw_code;
  logic [6:0]  fine_bin_code;
  logic        fine_code_err;

  int vectors;
  int miscompares;

  typedef struct {
    logic [54:0] raw;
    logic [6:0]  code;
    logic        err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fine_data_encoder dut (
    .clk40M        (clk40M),
    .rst_n         (rst_n),
    .fine_raw_code (fine_raw_code),
    .fine_bin_code (fine_bin_code),
    .fine_code_err (fine_code_err)
  );

  initial clk40M = 1'b0;
  always #10 clk40M = ~clk40M;

  task automatic check(input string name, input logic [6:0] exp_code, input logic exp_err);
    vectors++;
    if (fine_bin_code !== exp_code || fine_code_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s: got code=%0d err=%0b, expected code=%0d err=%0b",
               name, fine_bin_code, fine_code_err, exp_code, exp_err);
    end
  endtask

  // Reference: length of the leading run equal to bit 0, and number of
  // adjacent-bit changes anywhere in the snapshot.
  function automatic void model(input logic [54:0] r, output logic [6:0] c, output logic e);
    int p;
    int n_trans;
    p = 1;
    while (p < 55 && r[p] == r[0]) p++;
    n_trans = 0;
    for (int i = 1; i < 55; i++) if (r[i] != r[i-1]) n_trans++;
    c = r[0] ? 7'(p - 1) : 7'(54 + p);
    e = (n_trans > 1);
  endfunction

  function automatic logic [54:0] thermo(input logic v, input int k);
    logic [54:0] r;
    for (int i = 0; i < 55; i++) r[i] = (i < k) ? v : ~v;
    return r;
  endfunction

  task automatic add(input logic [54:0] raw, input int code, input logic err, input string name);
    vec_t t;
    t.raw = raw; t.code = 7'(code); t.err = err; t.name = name;
    vecs.push_back(t);
  endtask

  initial begin
    logic [54:0] r;
    logic [6:0]  pc;
    logic        pe;
    logic [6:0]  mc;
    logic        me;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    fine_raw_code = '0;

    // Reset asserted mid-cycle must clear a non-zero result immediately.
    repeat (2) @(negedge clk40M);
    check("pre_reset_all_zeros", 7'd109, 1'b0);
    #3 rst_n = 1'b0;
    fine_raw_code = {$urandom, $urandom};
    #1 check("reset_async", 7'd0, 1'b0);
    repeat (2) begin
      @(negedge clk40M);
      fine_raw_code = {$urandom, $urandom};
      check("reset_held", 7'd0, 1'b0);
    end
    rst_n = 1'b1;
    fine_raw_code = 55'h1;
    @(negedge clk40M);
    check("after_release", 7'd0, 1'b0);

    // Directed table.
    for (int k = 1; k <= 55; k++) add(thermo(1'b1, k), k - 1, 1'b0, $sformatf("ones_k%0d", k));
    for (int k = 1; k <= 55; k++) add(thermo(1'b0, k), 54 + k, 1'b0, $sformatf("zeros_k%0d", k));
    add(thermo(1'b1, 5),  4,   1'b0, "bnd_4_5_v1");
    add(thermo(1'b1, 10), 9,   1'b0, "bnd_9_10_v1");
    add(thermo(1'b1, 50), 49,  1'b0, "bnd_49_50_v1");
    add(thermo(1'b0, 5),  59,  1'b0, "bnd_4_5_v0");
    add(thermo(1'b0, 10), 64,  1'b0, "bnd_9_10_v0");
    add(thermo(1'b0, 50), 104, 1'b0, "bnd_49_50_v0");
    add(55'h5, 0, 1'b1, "bubble_0101");
    r = 55'h7;
    r[30] = 1'b1;
    add(r, 2, 1'b1, "bubble_cross_group");
    r = thermo(1'b0, 20);
    r[52] = 1'b0;
    add(r, 74, 1'b1, "bubble_high_zero");

    foreach (vecs[i]) begin
      @(negedge clk40M);
      fine_raw_code = vecs[i].raw;
      @(negedge clk40M);
      check(vecs[i].name, vecs[i].code, vecs[i].err);
    end

    // Back-to-back stream: output at each negedge belongs to the input
    // driven one cycle earlier.
    pc = '0;
    pe = 1'b0;
    for (int n = 0; n <= 2000; n++) begin
      @(negedge clk40M);
      if (n > 0) check($sformatf("stream_%0d", n - 1), pc, pe);
      if (n < 2000) begin
        r = thermo(1'($urandom_range(0, 1)), int'($urandom_range(1, 55)));
        fine_raw_code = r;
        model(r, mc, me);
        pc = mc;
        pe = me;
      end
    end

    // Arbitrary snapshots, mostly multi-transition, against the model.
    for (int n = 0; n <= 200; n++) begin
      @(negedge clk40M);
      if (n > 0) check($sformatf("rand_raw_%0d", n - 1), pc, pe);
      if (n < 200) begin
        r = {23'($urandom), $urandom};
        fine_raw_code = r;
        model(r, mc, me);
        pc = mc;
        pe = me;
      end
    end

    // Reset mid-stream discards the pending result.
    fine_raw_code = thermo(1'b0, 30);
    @(posedge clk40M);
    #2 rst_n = 1'b0;
    #1 check("reset_midstream", 7'd0, 1'b0);
    @(negedge clk40M);
    rst_n = 1'b1;
    fine_raw_code = thermo(1'b1, 37);
    @(negedge clk40M);
    check("after_midstream_release", 7'd36, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
